// File: rtl/button_debounce.sv
// Per-channel push-button conditioning: 2-flop synchronizer, debounce counter,
// press/release pulses, sticky W1C pending latch. Optional irq via BUTTON_DEBOUNCE_IRQ_EN.
module button_debounce #(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] btn_state,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] evt_pending,
    output logic             irq
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s0_q;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        pend_d    = pend_q & ~evt_clr;
        cnt_d     = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s0_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                // Terminal count: commit the new level; a press overrides a same-edge clear.
                state_d[i]   = s0_q[i];
                cnt_d[i]     = '0;
                press_d[i]   = s0_q[i];
                release_d[i] = ~s0_q[i];
                if (s0_q[i]) begin
                    pend_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s0_q      <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            pend_q    <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= btn_in;
            s0_q      <= s1_q;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            pend_q    <= pend_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef BUTTON_DEBOUNCE_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |pend_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign btn_state   = state_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign evt_pending = pend_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (DEBOUNCE_CYCLES=4): vector table,
// hand-written corner sequences, and randomized stimulus against a window-based model.
module tb_button_debounce;

    localparam int unsigned W = 3;
    localparam int unsigned D = 4;
`ifdef BUTTON_DEBOUNCE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] btn_in = '0;
    logic [W-1:0] evt_clr = '0;
    logic [W-1:0] btn_state, btn_press, btn_release, evt_pending;
    logic         irq;

    button_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .evt_clr     (evt_clr),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .evt_pending (evt_pending),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stable level flips when the last D synchronized
    // samples all disagree with it; samples reach the debouncer two edges late.
    logic [W-1:0] smp[$];
    logic [W-1:0] m_state, m_press, m_rel, m_pend;
    logic         m_irq;

    task automatic model_reset();
        m_state = '0;
        m_press = '0;
        m_rel   = '0;
        m_pend  = '0;
        m_irq   = 1'b0;
        smp.delete();
        repeat (D + 2) smp.push_back('0);
    endtask

    task automatic model_edge(input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] prev_pend;
        logic [W-1:0] flip;
        int L;
        prev_pend = m_pend;
        smp.push_back(b);
        if (smp.size() > D + 8) void'(smp.pop_front());
        L = smp.size();
        flip = '0;
        for (int i = 0; i < W; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (smp[L-3-j][i] == m_state[i]) all_diff = 1'b0;
            end
            flip[i] = all_diff;
        end
        m_press = flip & ~m_state;
        m_rel   = flip & m_state;
        m_state = m_state ^ flip;
        m_pend  = (m_pend & ~c) | m_press;
        m_irq   = IRQ_EN ? (|prev_pend) : 1'b0;
    endtask

    task automatic step(input logic [W-1:0] b, input logic [W-1:0] c);
        @(negedge clk);
        btn_in  = b;
        evt_clr = c;
        @(posedge clk);
        model_edge(b, c);
        #1;
        check("state",   32'(btn_state),   32'(m_state));
        check("press",   32'(btn_press),   32'(m_press));
        check("release", 32'(btn_release), 32'(m_rel));
        check("pending", 32'(evt_pending), 32'(m_pend));
        check("irq",     32'(irq),         32'(m_irq));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"},   32'(btn_state),   32'h0);
        check({tag, "_press"},   32'(btn_press),   32'h0);
        check({tag, "_release"}, 32'(btn_release), 32'h0);
        check({tag, "_pending"}, 32'(evt_pending), 32'h0);
        check({tag, "_irq"},     32'(irq),         32'h0);
    endtask

    // Called at posedge+1: reset lands mid-cycle, held through one edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_zero({tag, "_async"});
        model_reset();
        @(posedge clk);
        #1;
        check_zero({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] btn;
        logic [W-1:0] clr;
        logic [W-1:0] st;
        logic [W-1:0] pr;
        logic [W-1:0] rl;
        logic [W-1:0] pd;
        logic         irq;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int press_cnt;
        int rise_at;
        logic [W-1:0] pend_snap;
        logic [W-1:0] b;
        logic [W-1:0] c;

        for (int k = 0; k < 5; k++) tbl[k] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[5] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001, 1'b0};
        tbl[6] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, IRQ_EN};
        tbl[7] = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Press on channel 0 with set/clear collision and follow-up clear.
        for (int k = 0; k < 8; k++) begin
            step(tbl[k].btn, tbl[k].clr);
            check("tbl_state",   32'(btn_state),   32'(tbl[k].st));
            check("tbl_press",   32'(btn_press),   32'(tbl[k].pr));
            check("tbl_release", 32'(btn_release), 32'(tbl[k].rl));
            check("tbl_pending", 32'(evt_pending), 32'(tbl[k].pd));
            check("tbl_irq",     32'(irq),         32'(tbl[k].irq));
        end

        // Bounce on channel 1: runs of 3 never qualify; final rise at index 8.
        press_cnt = 0;
        rise_at   = -1;
        for (int k = 0; k < 18; k++) begin
            b = 3'b001;
            b[1] = !(k == 3 || k == 7);
            step(b, 3'b000);
            if (btn_press[1]) press_cnt++;
            if (btn_state[1] && rise_at < 0) rise_at = k;
        end
        check("bounce_press_count", 32'(press_cnt), 32'd1);
        check("bounce_rise_edge",   32'(rise_at),   32'd13);

        // Release on channel 2 after it has been pressed.
        repeat (6) step(3'b111, 3'b000);
        check("ch2_pressed", 32'(btn_state[2]), 32'd1);
        pend_snap = evt_pending;
        for (int k = 1; k <= 6; k++) begin
            step(3'b011, 3'b000);
            check("rel_pulse", 32'(btn_release[2]), (k == 6) ? 32'd1 : 32'd0);
            check("rel_state", 32'(btn_state[2]),   (k == 6) ? 32'd0 : 32'd1);
            check("rel_pend",  32'(evt_pending),    32'(pend_snap));
        end

        // Reset at count 2 with the input already gone: no press afterwards.
        repeat (4) step(3'b111, 3'b000);
        btn_in = 3'b000;
        do_reset("rst_low");
        press_cnt = 0;
        repeat (10) begin
            step(3'b000, 3'b000);
            if (btn_press != '0) press_cnt++;
        end
        check("rst_low_no_press", 32'(press_cnt), 32'd0);

        // Reset at count 2 with the input still high: full latency from scratch.
        repeat (4) step(3'b100, 3'b000);
        do_reset("rst_high");
        for (int k = 1; k <= 6; k++) begin
            step(3'b100, 3'b000);
            check("rst_high_press", 32'(btn_press),   (k == 6) ? 32'h4 : 32'h0);
            check("rst_high_pend",  32'(evt_pending), (k == 6) ? 32'h4 : 32'h0);
        end

        // Randomized traffic with occasional clears and asynchronous resets.
        b = btn_in;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
            end
            c = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            step(b, c);
            if ($urandom_range(0, 399) == 0) do_reset("rnd_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Input-side counterpart of the SoC LED outputs: conditions raw, asynchronous push-button levels into clean, debounced signals for the core and its peripherals. Each channel has a two-flop synchronizer, a per-channel debounce counter, registered press/release pulses and a sticky write-1-to-clear press latch. The block sits in the SoC top next to the clock/reset generator, in the divided `clk` domain, with reset `rst_n`.

## Interface
- `WIDTH`, 3: number of button channels.
- `DEBOUNCE_CYCLES`, 1000: consecutive `clk` cycles the synchronized input must differ from the stable state before the stable state changes. Must be ≥ 1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; release is synchronous to `clk` upstream.
- `btn_in`  in  WIDTH  raw button levels, asynchronous, active-high.
- `evt_clr`  in  WIDTH  write-1-to-clear strobe for `evt_pending`, sampled every cycle.
- `btn_state`  out  WIDTH  debounced level.
- `btn_press`  out  WIDTH  one-cycle pulse on a debounced 0→1 transition.
- `btn_release`  out  WIDTH  one-cycle pulse on a debounced 1→0 transition.
- `evt_pending`  out  WIDTH  sticky latch, set by a press.
- `irq`  out  1  interrupt request; see Configuration.

## Operation
- Channels are fully independent. Identical logic is replicated per bit `i`.
- Synchronizer: `s1[i] <= btn_in[i]`, `s0[i] <= s1[i]`. `s0` is the only value the debounce logic uses.
- Debounce counter `cnt[i]`:
  - Width is `$clog2(DEBOUNCE_CYCLES)`, with a minimum of 1.
  - When `s0 == btn_state`: `cnt <= 0`.
  - When they differ and `cnt == DEBOUNCE_CYCLES-1`: `btn_state <= s0` and `cnt <= 0`.
  - When they differ otherwise: `cnt <= cnt+1`.
  - Any glitch back to the stable value restarts the count from 0.
  - The counter never wraps.
- Pulses:
  - `btn_press` is registered high for exactly one cycle on the edge where `btn_state` goes 0→1.
  - `btn_release` behaves the same way for 1→0.
  - Press and release never assert together on one channel.
- Pending latch:
  - Set on the edge where `btn_press` is asserted.
  - Cleared on an edge where `evt_clr[i]` = 1.
  - If set and clear occur on the same edge, set wins; the latch stays 1.
  - Clearing an already-clear bit has no effect.
- Reset values: all synchronizer flops, counters and outputs are 0.
  - A button held high through reset release produces a normal press, with press pulse and pending set, after the standard latency.
- Reset asserted mid-count: the count is discarded and all outputs go to 0 immediately (asynchronously). No pulse is generated.

## Timing
- Latency from a stable change on `btn_in` to `btn_state`/pulse: `DEBOUNCE_CYCLES+2` rising edges.
  - The sampling edge into `s1` counts as edge 1.
- `btn_press`, `btn_release` and `btn_state` change on the same edge.
- `evt_pending` rises on the same edge as `btn_press`.
- `evt_pending` falls on the first edge at which `evt_clr` is sampled high.
- Minimum spacing between two debounced transitions on one channel is `DEBOUNCE_CYCLES` cycles.
- `irq` is registered and lags `evt_pending` by one edge.

## Configuration
- Macro: `BUTTON_DEBOUNCE_IRQ_EN`.
- Defined: `irq <= |evt_pending` on each edge. Reset value is 0. `irq` deasserts one edge after the last pending bit clears.
- Undefined: `irq` is tied to constant 0 and no flop is inferred. The port remains, so the SoC top connects identically either way. All other behaviour is unchanged.

## Test plan
- `DEBOUNCE_CYCLES`=4, `btn_in[0]` 0→1 held → `btn_state[0]`=1, a `btn_press[0]` pulse of 1 cycle, and `evt_pending[0]`=1, all at edge 6. Other channels stay 0.
- Bounce on `btn_in[1]`: high 3 cycles, low 1, high 3, low 1, then held high → no state change during the bounces. State rises 6 edges after the final rise. Exactly one press pulse.
- `evt_clr`=3'b001 driven on the same edge as a `btn_press[0]` pulse → `evt_pending[0]` remains 1. `evt_clr` pulsed one cycle later → `evt_pending[0]`=0 on the next edge.
- Release: held-high `btn_in[2]` goes 1→0 → `btn_release[2]` 1-cycle pulse and `btn_state[2]`=0 at edge 6. `evt_pending` is unchanged.
- `rst_n` pulled low at count 2 of a pending press → all outputs read 0 immediately. No press pulse appears after release, unless the input is still high, in which case a full 6-edge latency applies.
- With `BUTTON_DEBOUNCE_IRQ_EN` defined → `irq`=1 one edge after `evt_pending` becomes non-zero, and 0 one edge after all bits clear. With the macro undefined → `irq`=0 throughout.
